ram_rd_streamer: RTL and testbench

RAM_RD_STREAMER -- requirements
Module: ram_rd_streamer

---
 rtl/ram_rd_streamer_pkg.sv | 15 +
 rtl/ram_rd_streamer_fifo.sv | 50 +++++
 rtl/ram_rd_streamer.sv | 142 ++++++++++++++
 tb/tb_ram_rd_streamer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_streamer_pkg.sv
// Shared defaults and FSM encoding for the RAM read streamer.
// Imported by the streamer top and its output FIFO.
package ram_rd_streamer_pkg;

  localparam int DW_DEF    = 64;
  localparam int AW_DEF    = 11;
  localparam int DEPTH_DEF = 1440;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_rd_streamer_fifo.sv
// Two-entry synchronous FIFO carrying {last, data} for the streamer.
// Head is shown combinationally; push and pop may share a cycle.
module sync_fifo_2 #(
  parameter int W = 65
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (cnt != 2'd0);
  assign do_push = push_i && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem0 <= '0;
      mem1 <= '0;
      wp   <= 1'b0;
      rp   <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wp) mem1 <= wdata_i;
        else    mem0 <= wdata_i;
        wp <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + {1'b0, do_push}
                 - {1'b0, do_pop};
    end
  end

  assign rdata_o = rp ? mem1 : mem0;
  assign empty_o = (cnt == 2'd0);
  assign count_o = cnt;

endmodule

// File: rtl/ram_rd_streamer.sv
// Streams a run of words out of a dual-port RAM read port.
// Reads are credit-limited so the 2-entry output FIFO never overflows.
module ram_rd_streamer
  import ram_rd_streamer_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW-1:0] cmd_len_i,
  output logic          ram_rd_en_o,
  output logic [AW-1:0] ram_rd_addr_o,
  input  logic [DW-1:0] ram_rd_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rem_q;
  logic          inflight_q;
  logic          inflight_last_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [1:0]    fifo_cnt;
  logic          fifo_empty;
  logic [DW:0]   fifo_rdata;
  logic          pop;
  logic          issue;
  logic          accept;
  logic          bad_cmd;
  logic [2:0]    credit;
  logic [1:0]    cnt_next;

  // Ready is held off during the done pulse so a
  // follow-on command lands no earlier than the next cycle.
  assign cmd_ready_o = (state == IDLE)
                    && !done_q && !rst_i;
  assign accept  = cmd_valid_i && cmd_ready_o;
  assign bad_cmd = (32'(cmd_addr_i) >= DEPTH)
                || (32'(cmd_len_i) > DEPTH);

  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;

  assign credit = {1'b0, fifo_cnt}
                + {2'b0, inflight_q}
                - {2'b0, pop};
  assign cnt_next = fifo_cnt
                  + {1'b0, inflight_q}
                  - {1'b0, pop};

  assign issue = (state == READ)
              && (rem_q != '0)
              && (credit <= 3'd1);

  assign ram_rd_en_o   = issue;
  assign ram_rd_addr_o = addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        inflight_last_q <= (rem_q == AW'(1));
        rem_q  <= rem_q - 1'b1;
        addr_q <= (addr_q == AW'(DEPTH - 1))
                ? '0 : addr_q + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (bad_cmd) begin
              err_q <= 1'b1;
            end else if (cmd_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state  <= READ;
              addr_q <= cmd_addr_i;
              rem_q  <= cmd_len_i;
              busy_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue && (rem_q == AW'(1)))
            state <= DRAIN;
        end
        DRAIN: begin
          // Finish on the edge that empties the FIFO.
          if (cnt_next == 2'd0) begin
            state  <= IDLE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo_2 #(
    .W(DW + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, ram_rd_data_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_data_o = fifo_rdata[DW-1:0];
  assign out_last_o = fifo_rdata[DW];

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Self-checking bench for ram_rd_streamer.
// Word-level scoreboard plus occupancy model of the output path.
module tb_ram_rd_streamer;
  import ram_rd_streamer_pkg::*;

  localparam int DW    = DW_DEF;
  localparam int AW    = AW_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [AW-1:0] cmd_len_i = '0;
  logic          ram_rd_en_o;
  logic [AW-1:0] ram_rd_addr_o;
  logic [DW-1:0] ram_rd_data_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  ram_rd_streamer #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .ram_rd_en_o   (ram_rd_en_o),
    .ram_rd_addr_o (ram_rd_addr_o),
    .ram_rd_data_i (ram_rd_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_last_o    (out_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk_i)
    if (ram_rd_en_o) ram_q <= mem[ram_rd_addr_o];
  assign ram_rd_data_i = ram_q;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } wexp_t;

  wexp_t exp_q[$];
  int    exp_addr[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rmode = 0;
  int rk = 0;
  int rem = 0, occ = 0, infl = 0;
  bit act = 0, done_exp = 0, err_exp = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_d;
  logic prev_l;
  int n_acc = 0, acc_cyc = 0;
  int n_rd, first_rd, last_rd;
  int first_val, n_pop, last_pop, n_last;
  int n_done = 0, done_cyc = 0;
  int n_err = 0, err_cyc = 0;
  int n_stall = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_ready"}, cmd_ready_o, 0);
    chk({t, "_rden"}, ram_rd_en_o, 0);
    chk({t, "_rdaddr"}, ram_rd_addr_o, 0);
    chk({t, "_valid"}, out_valid_o, 0);
    chk({t, "_data"}, out_data_o, 0);
    chk({t, "_last"}, out_last_o, 0);
    chk({t, "_busy"}, busy_o, 0);
    chk({t, "_done"}, done_o, 0);
    chk({t, "_err"}, err_o, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr.delete();
    rem = 0; occ = 0; infl = 0;
    act = 0; done_exp = 0; err_exp = 0;
    prev_stall = 0;
  endtask

  // One clock of stimulus, model update and checks.
  task automatic step();
    int cred, a0, ln, ad;
    bit pop, issue;
    wexp_t w;
    case (rmode)
      0: out_ready_i = 1'b1;
      1: out_ready_i = (rk % 3 == 0);
      default: out_ready_i =
        ($urandom_range(0, 3) != 0);
    endcase
    rk++;
    #1;
    pop   = (occ > 0) && out_ready_i;
    cred  = occ + infl - int'(pop);
    issue = (rem > 0) && (cred <= 1);
    chk("out_valid", out_valid_o, occ > 0);
    chk("rd_en", ram_rd_en_o, issue);
    chk("busy", busy_o, act);
    chk("done", done_o, done_exp);
    chk("err", err_o, err_exp);
    if (act) chk("ready_busy", cmd_ready_o, 0);
    if (prev_stall) begin
      chk("hold_data", out_data_o, prev_d);
      chk("hold_last", out_last_o, prev_l);
    end
    if (rem > 0 && cred > 1) n_stall++;
    done_exp = 0;
    err_exp  = 0;
    if (issue) begin
      if (exp_addr.size() == 0)
        chk("rd_extra", 1, 0);
      else
        chk("rd_addr", ram_rd_addr_o,
            exp_addr.pop_front());
      rem--;
    end
    if (ram_rd_en_o) begin
      n_rd++;
      last_rd = cyc;
      if (first_rd < 0) first_rd = cyc;
    end
    if (out_valid_o && first_val < 0)
      first_val = cyc;
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("pop_extra", 1, 0);
      end else begin
        w = exp_q.pop_front();
        chk("out_data", out_data_o, w.d);
        chk("out_last", out_last_o, w.l);
        if (w.l) begin
          done_exp = 1;
          act = 0;
        end
      end
      n_pop++;
      last_pop = cyc;
      if (out_last_o) n_last++;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err_o) begin
      n_err++;
      err_cyc = cyc;
    end
    if (cmd_valid_i && cmd_ready_o) begin
      n_acc++;
      acc_cyc = cyc;
      a0 = int'(cmd_addr_i);
      ln = int'(cmd_len_i);
      if (a0 >= DEPTH || ln > DEPTH) begin
        err_exp = 1;
      end else if (ln == 0) begin
        done_exp = 1;
      end else begin
        act = 1;
        rem = ln;
        for (int i = 0; i < ln; i++) begin
          ad = (a0 + i) % DEPTH;
          exp_addr.push_back(ad);
          w.l = (i == ln - 1);
          w.d = mem[ad];
          exp_q.push_back(w);
        end
      end
    end
    prev_stall = out_valid_o && !out_ready_i;
    prev_d = out_data_o;
    prev_l = out_last_o;
    occ  = occ + infl - int'(pop);
    infl = int'(issue);
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic run_cmd(input int a,
                         input int l,
                         input int mode);
    int k, t;
    rmode = mode;
    rk = 0;
    first_rd = -1;
    first_val = -1;
    n_rd = 0;
    n_pop = 0;
    n_last = 0;
    k = n_acc;
    cmd_valid_i = 1'b1;
    cmd_addr_i = AW'(a);
    cmd_len_i = AW'(l);
    t = 0;
    while (n_acc == k && t < 100) begin
      step();
      t++;
    end
    cmd_valid_i = 1'b0;
    chk("accept", n_acc, k + 1);
    t = 0;
    while ((act || done_exp || err_exp)
           && t < l * 10 + 100) begin
      step();
      t++;
    end
    chk("complete", act, 0);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    int a, k, t, nd, ne, a2, d1, ln;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = {$urandom, $urandom};

    #3;
    chk_reset_vals("rst");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready_o, 1);

    // Basic 4-word stream, latency and last/done timing.
    run_cmd(0, 4, 0);
    a = acc_cyc;
    chk("t1_first_rd", first_rd, a + 1);
    chk("t1_last_rd", last_rd, a + 4);
    chk("t1_n_rd", n_rd, 4);
    chk("t1_first_val", first_val, a + 3);
    chk("t1_n_pop", n_pop, 4);
    chk("t1_last_pop", last_pop, a + 6);
    chk("t1_n_last", n_last, 1);
    chk("t1_done", done_cyc, last_pop + 1);

    // Address wrap at DEPTH-1.
    run_cmd(1438, 4, 0);
    chk("t2_n_rd", n_rd, 4);
    chk("t2_n_pop", n_pop, 4);

    // Backpressure 1,0,0,...
    n_stall = 0;
    run_cmd(300, 8, 1);
    chk("t3_n_pop", n_pop, 8);
    chk("t3_n_last", n_last, 1);
    chk("t3_stalled", n_stall > 0, 1);

    // Rejected and empty commands.
    nd = n_done;
    run_cmd(1440, 1, 0);
    chk("t4a_err", err_cyc, acc_cyc + 1);
    chk("t4a_n_rd", n_rd, 0);
    run_cmd(0, 1441, 0);
    chk("t4b_err", err_cyc, acc_cyc + 1);
    chk("t4b_n_rd", n_rd, 0);
    chk("t4b_nodone", n_done, nd);
    ne = n_err;
    run_cmd(7, 0, 0);
    chk("t4c_done", done_cyc, acc_cyc + 1);
    chk("t4c_n_rd", n_rd, 0);
    chk("t4c_n_pop", n_pop, 0);
    chk("t4c_noerr", n_err, ne);

    // Reset in the middle of a 16-word read.
    rmode = 0;
    k = n_acc;
    cmd_valid_i = 1'b1;
    cmd_addr_i = AW'(100);
    cmd_len_i = AW'(16);
    t = 0;
    while (n_acc == k && t < 100) begin
      step();
      t++;
    end
    cmd_valid_i = 1'b0;
    repeat (5) step();
    nd = n_done;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("midrst");
    clear_model();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("ready_after_midrst", cmd_ready_o, 1);
    repeat (3) step();
    chk("t5_nodone", n_done, nd);
    run_cmd(5, 2, 0);
    chk("t5_n_pop", n_pop, 2);
    chk("t5_n_last", n_last, 1);

    // cmd_valid held high across two commands.
    rmode = 0;
    k = n_acc;
    cmd_valid_i = 1'b1;
    cmd_addr_i = AW'(10);
    cmd_len_i = AW'(3);
    t = 0;
    while (n_acc == k && t < 100) begin
      step();
      t++;
    end
    cmd_addr_i = AW'(200);
    cmd_len_i = AW'(5);
    t = 0;
    while (n_acc == k + 1 && t < 200) begin
      step();
      t++;
    end
    cmd_valid_i = 1'b0;
    a2 = acc_cyc;
    d1 = done_cyc;
    chk("t6_accept2", n_acc, k + 2);
    chk("t6_gap", a2, d1 + 1);
    t = 0;
    while ((act || done_exp) && t < 200) begin
      step();
      t++;
    end
    chk("t6_complete", act, 0);
    chk("t6_drained", exp_q.size(), 0);

    // Random commands with random backpressure.
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      ln = $urandom_range(1, 40);
      run_cmd(a, ln, 2);
      chk("rnd_n_pop", n_pop, ln);
      chk("rnd_n_rd", n_rd, ln);
      chk("rnd_n_last", n_last, 1);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
